// File: rtl/dsm_pkg.sv
// Shared types and defaults for the delta-sigma start-up/shut-down sequencer.
package dsm_pkg;

  localparam int DSM_W  = 20;
  localparam int DSM_GW = 8;

  // Unity gain for the default gain resolution.
  localparam logic [DSM_GW:0] DSM_UNITY = {1'b1, {DSM_GW{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } dsm_state_e;

  // States in which the datapath is live: dither flows and overload is watched.
  function automatic logic is_active(input dsm_state_e s);
    logic act;
    case (s)
      ST_FLUSH, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN: act = 1'b1;
      default:                                    act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/dsm_gain_mul.sv
// Registered signed gain scaler: vin_o = floor(vin_i * gain / 2**GW).
module dsm_gain_mul
  import dsm_pkg::*;
#(
  parameter int W  = DSM_W,
  parameter int GW = DSM_GW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic signed [W-1:0] vin_i,
  input  logic [GW:0]         gain_i,
  output logic signed [W-1:0] vin_o
);

  // Wide enough for a signed W-bit sample times a non-negative (GW+1)-bit gain.
  localparam int PW = W + GW + 2;

  logic signed [PW-1:0] prod_s;
  logic signed [W-1:0]  vin_d;
  logic signed [W-1:0]  vin_q;

  // Multiply and floor-shift; gain never exceeds unity so the result fits in W bits.
  always_comb begin
    prod_s = PW'(vin_i) * PW'($signed({1'b0, gain_i}));
    vin_d  = W'(prod_s >>> GW);
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vin_q <= {W{1'b0}};
    end else begin
      vin_q <= vin_d;
    end
  end

  assign vin_o = vin_q;

endmodule

// File: rtl/dsm_seq.sv
// Start-up/shut-down sequencer and overload supervisor for the modulator chain.
module dsm_seq
  import dsm_pkg::*;
#(
  parameter int W         = DSM_W,
  parameter int GW        = DSM_GW,
  parameter int FLUSH_CYC = 64,
  parameter int RAMP_DIV  = 16,
  parameter int OVL_LIM   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                ovl_i,
  input  logic signed [W-1:0] vin_i,
  input  logic signed [W-1:0] dith_i,
  output logic signed [W-1:0] vin_o,
  output logic signed [W-1:0] dith_o,
  output logic                dp_rst,
  output logic                running,
  output logic                fault,
  output logic [2:0]          state_o
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int DW = $clog2(RAMP_DIV + 1);
  localparam int OW = $clog2(OVL_LIM + 1);

  localparam logic [GW:0]   UNITY      = {1'b1, {GW{1'b0}}};
  localparam logic [GW:0]   GAIN_ZERO  = {(GW+1){1'b0}};
  localparam logic [GW:0]   GAIN_ONE   = {{GW{1'b0}}, 1'b1};
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [FW-1:0] FLUSH_DONE = FW'(FLUSH_CYC);
  localparam logic [DW-1:0] DIV_LAST   = DW'(RAMP_DIV - 1);
  localparam logic [OW-1:0] OVL_MAX    = OW'(OVL_LIM);

  dsm_state_e          state_q, state_d;
  logic [GW:0]         gain_q, gain_d;
  logic [DW-1:0]       div_q, div_d;
  logic [FW-1:0]       flush_q, flush_d;
  logic [OW-1:0]       ovl_q, ovl_d;
  logic signed [W-1:0] dith_o_q, dith_o_d;
  logic                dp_rst_q, dp_rst_d;
  logic                running_q, running_d;
  logic                fault_q, fault_d;
  logic [GW:0]         gain_inc_s, gain_dec_s, mul_gain_s;
  logic                ovl_trip_s;

  assign gain_inc_s = gain_q + GAIN_ONE;
  assign gain_dec_s = gain_q - GAIN_ONE;

  // Consecutive-overload counter: live states only, saturating, trips at the limit.
  always_comb begin
    ovl_d = {OW{1'b0}};
    if (is_active(state_q) && ovl_i) begin
      if (ovl_q == OVL_MAX) begin
        ovl_d = ovl_q;
      end else begin
        ovl_d = ovl_q + OW'(1);
      end
    end else begin
      ovl_d = {OW{1'b0}};
    end
    ovl_trip_s = (ovl_d == OVL_MAX);
  end

  // Next state and gain; overload beats an en change, which beats a counter expiry.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      ST_IDLE: begin
        gain_d = GAIN_ZERO;
        if (en) state_d = ST_FLUSH;
        else    state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        gain_d = GAIN_ZERO;
        if (ovl_trip_s)                state_d = ST_FAULT;
        else if (!en)                  state_d = ST_IDLE;
        else if (flush_q == FLUSH_LAST) state_d = ST_RAMP_UP;
        else                           state_d = ST_FLUSH;
      end
      ST_RAMP_UP: begin
        if (ovl_trip_s) begin
          state_d = ST_FAULT;
          gain_d  = GAIN_ZERO;
        end else if (!en) begin
          state_d = ST_RAMP_DOWN;
        end else if (gain_q == UNITY) begin
          state_d = ST_RUN;
        end else if (div_q == DIV_LAST) begin
          gain_d = gain_inc_s;
          if (gain_inc_s == UNITY) state_d = ST_RUN;
          else                     state_d = ST_RAMP_UP;
        end else begin
          state_d = ST_RAMP_UP;
        end
      end
      ST_RUN: begin
        if (ovl_trip_s) begin
          state_d = ST_FAULT;
          gain_d  = GAIN_ZERO;
        end else if (!en) begin
          state_d = ST_RAMP_DOWN;
          gain_d  = UNITY;
        end else begin
          state_d = ST_RUN;
          gain_d  = UNITY;
        end
      end
      ST_RAMP_DOWN: begin
        if (ovl_trip_s) begin
          state_d = ST_FAULT;
          gain_d  = GAIN_ZERO;
        end else if (en) begin
          state_d = ST_RAMP_UP;
        end else if (gain_q == GAIN_ZERO) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          gain_d = gain_dec_s;
          if (gain_dec_s == GAIN_ZERO) state_d = ST_IDLE;
          else                         state_d = ST_RAMP_DOWN;
        end else begin
          state_d = ST_RAMP_DOWN;
        end
      end
      ST_FAULT: begin
        gain_d = GAIN_ZERO;
        if ((flush_q == FLUSH_DONE) && !en) state_d = ST_IDLE;
        else                                state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
        gain_d  = GAIN_ZERO;
      end
    endcase
  end

  // Step divider and flush/hold counter; both restart whenever the state changes.
  always_comb begin
    div_d   = {DW{1'b0}};
    flush_d = {FW{1'b0}};
    if (state_d != state_q) begin
      div_d   = {DW{1'b0}};
      flush_d = {FW{1'b0}};
    end else begin
      if ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN)) begin
        if (div_q == DIV_LAST) div_d = {DW{1'b0}};
        else                   div_d = div_q + DW'(1);
      end else begin
        div_d = {DW{1'b0}};
      end
      if ((state_q == ST_FLUSH) || (state_q == ST_FAULT)) begin
        if (flush_q == FLUSH_DONE) flush_d = flush_q;
        else                       flush_d = flush_q + FW'(1);
      end else begin
        flush_d = {FW{1'b0}};
      end
    end
  end

  // Output decode from the upcoming state so the flags line up with state_o.
  always_comb begin
    dp_rst_d  = (state_d == ST_IDLE) ||
                ((state_d == ST_FAULT) && (flush_d != FLUSH_DONE));
    running_d = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
    if (is_active(state_d)) begin
      dith_o_d = dith_i;
    end else begin
      dith_o_d = {W{1'b0}};
    end
    // Mute the scaler on the very edge that enters FAULT.
    if (state_d == ST_FAULT) begin
      mul_gain_s = GAIN_ZERO;
    end else begin
      mul_gain_s = gain_q;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gain_q    <= GAIN_ZERO;
      div_q     <= {DW{1'b0}};
      flush_q   <= {FW{1'b0}};
      ovl_q     <= {OW{1'b0}};
      dith_o_q  <= {W{1'b0}};
      dp_rst_q  <= 1'b1;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      div_q     <= div_d;
      flush_q   <= flush_d;
      ovl_q     <= ovl_d;
      dith_o_q  <= dith_o_d;
      dp_rst_q  <= dp_rst_d;
      running_q <= running_d;
      fault_q   <= fault_d;
    end
  end

  dsm_gain_mul #(
    .W  (W),
    .GW (GW)
  ) u_gain_mul (
    .clock  (clock),
    .reset  (reset),
    .vin_i  (vin_i),
    .gain_i (mul_gain_s),
    .vin_o  (vin_o)
  );

  assign dith_o  = dith_o_q;
  assign dp_rst  = dp_rst_q;
  assign running = running_q;
  assign fault   = fault_q;
  assign state_o = state_q;

endmodule
